// File: rtl/multibyte_add_pkg.sv
// Shared types and constants for the byte-serial multi-limb adder.
package multibyte_add_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_8b_cin.sv
// Combinational 8-bit adder slice with carry-in; the one shared datapath element.
module adder_8b_cin
  import multibyte_add_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, cin};

endmodule

// File: rtl/multibyte_add_seq.sv
// Byte-serial NBYTES-limb adder reusing one 8-bit slice, LSB limb first.
// Defining MULTIBYTE_ADD_SEQ_SUB_EN adds a 'sub' port for A-B (carry=1 means no borrow).
module multibyte_add_seq
  import multibyte_add_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
`ifdef MULTIBYTE_ADD_SEQ_SUB_EN
  input  logic                     sub,
`endif
  output logic                     busy,
  output logic                     done,
  output logic [BYTE_W*NBYTES-1:0] sum,
  output logic                     carry
);

  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int OPW = BYTE_W * NBYTES;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  state_t            state;
  logic [CW-1:0]     count;
  logic              carryFlop;
  logic [OPW-1:0]    opA;
  logic [OPW-1:0]    opB;
  logic [BYTE_W-1:0] limbA;
  logic [BYTE_W-1:0] limbB;
  logic [BYTE_W-1:0] sliceSum;
  logic              sliceCout;
  logic              subMode;
  logic              acceptCin;

`ifdef MULTIBYTE_ADD_SEQ_SUB_EN
  logic subReg;
  // Subtraction is A + ~B + 1: invert the B limb and seed the carry chain with 1.
  assign subMode   = subReg;
  assign acceptCin = sub;
`else
  assign subMode   = 1'b0;
  assign acceptCin = 1'b0;
`endif

  assign limbA = opA[BYTE_W*count +: BYTE_W];
  assign limbB = opB[BYTE_W*count +: BYTE_W] ^ {BYTE_W{subMode}};

  adder_8b_cin u_slice (
    .a    (limbA),
    .b    (limbB),
    .cin  (carryFlop),
    .sum  (sliceSum),
    .cout (sliceCout)
  );

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      count     <= '0;
      carryFlop <= 1'b0;
      opA       <= '0;
      opB       <= '0;
      sum       <= '0;
      carry     <= 1'b0;
`ifdef MULTIBYTE_ADD_SEQ_SUB_EN
      subReg    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opA       <= a;
            opB       <= b;
            sum       <= '0;
            count     <= '0;
            carryFlop <= acceptCin;
`ifdef MULTIBYTE_ADD_SEQ_SUB_EN
            subReg    <= sub;
`endif
            state     <= RUN;
          end
        end
        RUN: begin
          sum[BYTE_W*count +: BYTE_W] <= sliceSum;
          carryFlop <= sliceCout;
          if (count == LAST) begin
            carry <= sliceCout;
            state <= DONE;
          end else begin
            count <= count + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Self-checking bench for multibyte_add_seq: a 4-limb and a 1-limb instance
// against an arithmetic reference model; honours MULTIBYTE_ADD_SEQ_SUB_EN.
module tb_multibyte_add_seq;

  localparam int NB  = 4;
  localparam int NB1 = 1;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start, start1;
  logic [8*NB-1:0] a, b, sum;
  logic [7:0]      a1, b1, sum1;
  logic            sub, sub1;
  logic            busy, done, carry;
  logic            busy1, done1, carry1;

  int compareCount = 0;
  int mismatchCount = 0;

  always #5 clk = ~clk;

  multibyte_add_seq #(.NBYTES(NB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .a       (a),
    .b       (b),
`ifdef MULTIBYTE_ADD_SEQ_SUB_EN
    .sub     (sub),
`endif
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .carry   (carry)
  );

  multibyte_add_seq #(.NBYTES(NB1)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start1),
    .a       (a1),
    .b       (b1),
`ifdef MULTIBYTE_ADD_SEQ_SUB_EN
    .sub     (sub1),
`endif
    .busy    (busy1),
    .done    (done1),
    .sum     (sum1),
    .carry   (carry1)
  );

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Unsigned sum/difference of nb-byte operands; carry is bit 8*nb, or "no borrow".
  function automatic void refModel(input int nb, input logic [127:0] x, input logic [127:0] y,
                                   input logic s, output logic [127:0] r, output logic c);
    logic [128:0] mask, full, xm, ym;
    mask = (129'd1 << (8 * nb)) - 129'd1;
    xm   = {1'b0, x} & mask;
    ym   = {1'b0, y} & mask;
    if (s) begin
      full = (xm - ym) & mask;
      c    = (xm >= ym);
    end else begin
      full = xm + ym;
      c    = full[8*nb];
    end
    r = full[127:0] & mask[127:0];
  endfunction

  function automatic logic randSub();
`ifdef MULTIBYTE_ADD_SEQ_SUB_EN
    return logic'($urandom_range(0, 1));
`else
    return 1'b0;
`endif
  endfunction

  // One operation on the 4-limb instance; injectAt>0 pulses a spurious start
  // that many cycles after acceptance.
  task automatic applyStimulus(input logic [8*NB-1:0] av, input logic [8*NB-1:0] bv,
                               input logic sv, input int injectAt);
    logic [127:0] expSum, gotSum;
    logic         expCarry, gotCarry;
    int busyCycles, donePulses, doneAt;
    refModel(NB, 128'(av), 128'(bv), sv, expSum, expCarry);
    busyCycles = 0; donePulses = 0; doneAt = -1; gotSum = '0; gotCarry = 1'b0;
    @(negedge clk);
    start = 1'b1; a = av; b = bv; sub = sv;
    for (int j = 0; j <= NB + 2; j++) begin
      @(negedge clk);
      if (j == 0) begin
        start = 1'b0; a = $urandom; b = $urandom; sub = randSub();
      end
      if (injectAt > 0 && j == injectAt) begin
        start = 1'b1; a = $urandom; b = $urandom; sub = randSub();
      end else if (injectAt > 0 && j == injectAt + 1) begin
        start = 1'b0;
      end
      if (busy) busyCycles++;
      if (done) begin
        donePulses++;
        if (doneAt < 0) begin
          doneAt = j; gotSum = 128'(sum); gotCarry = carry;
        end
      end
    end
    start = 1'b0;
    checkOutput("doneLatency", 128'(doneAt), 128'(NB));
    checkOutput("busyCycles", 128'(busyCycles), 128'(NB));
    checkOutput("donePulses", 128'(donePulses), 128'd1);
    checkOutput("sum", gotSum, expSum);
    checkOutput("carry", 128'(gotCarry), 128'(expCarry));
    checkOutput("sumHeld", 128'(sum), expSum);
    checkOutput("carryHeld", 128'(carry), 128'(expCarry));
  endtask

  task automatic applyStimulusSmall(input logic [7:0] av, input logic [7:0] bv, input logic sv);
    logic [127:0] expSum, gotSum;
    logic         expCarry, gotCarry;
    int busyCycles, donePulses, doneAt;
    refModel(NB1, 128'(av), 128'(bv), sv, expSum, expCarry);
    busyCycles = 0; donePulses = 0; doneAt = -1; gotSum = '0; gotCarry = 1'b0;
    @(negedge clk);
    start1 = 1'b1; a1 = av; b1 = bv; sub1 = sv;
    for (int j = 0; j <= NB1 + 2; j++) begin
      @(negedge clk);
      if (j == 0) begin
        start1 = 1'b0; a1 = 8'($urandom); b1 = 8'($urandom);
      end
      if (busy1) busyCycles++;
      if (done1) begin
        donePulses++;
        if (doneAt < 0) begin
          doneAt = j; gotSum = 128'(sum1); gotCarry = carry1;
        end
      end
    end
    checkOutput("nb1DoneLatency", 128'(doneAt), 128'(NB1));
    checkOutput("nb1BusyCycles", 128'(busyCycles), 128'(NB1));
    checkOutput("nb1DonePulses", 128'(donePulses), 128'd1);
    checkOutput("nb1Sum", gotSum, expSum);
    checkOutput("nb1Carry", 128'(gotCarry), 128'(expCarry));
  endtask

  initial begin
    int doneSeen;
    reset_n = 1'b0; start = 1'b0; start1 = 1'b0;
    a = '0; b = '0; a1 = '0; b1 = '0; sub = 1'b0; sub1 = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    checkOutput("resetBusy", 128'(busy), 128'd0);
    checkOutput("resetDone", 128'(done), 128'd0);
    checkOutput("resetSum", 128'(sum), 128'd0);
    checkOutput("resetCarry", 128'(carry), 128'd0);
    checkOutput("resetSum1", 128'(sum1), 128'd0);

    applyStimulus(32'h000000FF, 32'h00000001, 1'b0, -1);
    applyStimulus(32'hFFFFFFFF, 32'h00000001, 1'b0, -1);

    // Abort in RUN after count reaches 2; carry still holds 1 from above.
    @(negedge clk);
    start = 1'b1; a = 32'hDEADBEEF; b = 32'h01020304;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checkOutput("abortBusy", 128'(busy), 128'd0);
    checkOutput("abortDone", 128'(done), 128'd0);
    checkOutput("abortSum", 128'(sum), 128'd0);
    checkOutput("abortCarry", 128'(carry), 128'd0);
    doneSeen = 0;
    for (int j = 0; j < NB + 3; j++) begin
      @(negedge clk);
      if (done || busy) doneSeen++;
    end
    checkOutput("abortQuiet", 128'(doneSeen), 128'd0);
    applyStimulus(32'h00000001, 32'h00000002, 1'b0, -1);

    applyStimulus(32'h12345678, 32'h11111111, 1'b0, 1);
    applyStimulus(32'h12345678, 32'h11111111, 1'b0, NB);

`ifdef MULTIBYTE_ADD_SEQ_SUB_EN
    applyStimulus(32'd5, 32'd7, 1'b1, -1);
    applyStimulus(32'd7, 32'd5, 1'b1, -1);
    applyStimulus(32'd9, 32'd9, 1'b1, -1);
`endif

    for (int i = 0; i < 20; i++) begin
      applyStimulus($urandom, $urandom, randSub(),
                    (i % 3 == 0) ? -1 : int'($urandom_range(1, NB)));
    end

    applyStimulusSmall(8'hC8, 8'h64, 1'b0);
    applyStimulusSmall(8'h01, 8'h02, 1'b0);
    for (int i = 0; i < 8; i++) begin
      applyStimulusSmall(8'($urandom), 8'($urandom), randSub());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
